// File: rtl/mcam_viol_handler.sv
// Memory-protection violation responder: latches the first violation of a burst,
// holds the device in reset and zero-fills the safe region before releasing it.
module mcam_viol_handler #(
  parameter int SIZE_MEM_ADDR = 15,
  parameter int LOW_SAFE      = 200,
  parameter int HIGH_SAFE     = 200,
  parameter int RST_CYCLES    = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                   mclk,
  input  logic                   reset_n,
  input  logic                   viol,
  input  logic [SIZE_MEM_ADDR:0] viol_addr,
  input  logic [15:0]            viol_pc,
  input  logic                   disable_debug,
  input  logic                   wipe_ack,
  output logic                   dev_reset,
  output logic                   wipe_req,
  output logic [SIZE_MEM_ADDR:0] wipe_addr,
  output logic [15:0]            wipe_data,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   viol_count,
  output logic [SIZE_MEM_ADDR:0] last_viol_addr,
  output logic [15:0]            last_viol_pc
);

  localparam int AW = SIZE_MEM_ADDR + 1;
  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [AW-1:0] LOW_A     = AW'(LOW_SAFE);
  localparam logic [AW-1:0] HIGH_A    = AW'(HIGH_SAFE);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, WIPE, DONE} state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;

  assign wipe_data = '0;

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      dev_reset      <= 1'b0;
      busy           <= 1'b0;
      wipe_req       <= 1'b0;
      wipe_addr      <= LOW_A;
      viol_count     <= '0;
      last_viol_addr <= '0;
      last_viol_pc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (viol && !disable_debug) begin
            state          <= HOLD;
            hold_cnt       <= HOLD_LOAD;
            dev_reset      <= 1'b1;
            busy           <= 1'b1;
            last_viol_addr <= viol_addr;
            last_viol_pc   <= viol_pc;
            if (viol_count != '1)
              viol_count <= viol_count + CNT_WIDTH'(1);
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state     <= WIPE;
            wipe_req  <= 1'b1;
            wipe_addr <= LOW_A;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        WIPE: begin
          // Address and request hold steady until the arbiter accepts the write.
          if (wipe_ack) begin
            if (wipe_addr == HIGH_A) begin
              state     <= DONE;
              wipe_req  <= 1'b0;
              wipe_addr <= LOW_A;
            end else begin
              wipe_addr <= wipe_addr + AW'(1);
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          dev_reset <= 1'b0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
